// File: rtl/skid_fifo.sv
// Elastic valid/ready buffer of DEPTH entries with optional zero-latency fall-through.
// Upstream ready is decoded from the stored count only, so it never depends on data_ready_i.
module skid_fifo #(
    parameter int unsigned DATA_SIZE    = 8,
    parameter int unsigned DEPTH        = 2,
    parameter bit          FALL_THROUGH = 1'b0
) (
    input  logic                         clk_i,
    input  logic                         rst_clk_ni,
    input  logic [DATA_SIZE-1:0]         data_i,
    input  logic                         data_valid_i,
    output logic                         data_ready_o,
    output logic [DATA_SIZE-1:0]         data_o,
    output logic                         data_valid_o,
    input  logic                         data_ready_i,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic                         full_o,
    output logic                         empty_o
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [DATA_SIZE-1:0] mem_q [DEPTH];
    logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        count_q, count_d;

    logic empty, full, bypass;
    logic push, pop, store, unload;

    assign empty = (count_q == '0);
    assign full  = (count_q == FULL_CNT);

    // Bypass only exists in fall-through mode while nothing is stored.
    assign bypass = FALL_THROUGH && empty;

    assign data_ready_o = !full;
    assign full_o       = full;
    assign empty_o      = empty;
    assign count_o      = count_q;

    always_comb begin
        data_o       = mem_q[rd_ptr_q];
        data_valid_o = !empty;
        if (bypass) begin
            data_o       = data_i;
            data_valid_o = data_valid_i;
        end
    end

    assign push = data_valid_i && data_ready_o;
    assign pop  = data_valid_o && data_ready_i;

    // A bypassed beat consumed in the same cycle never touches storage.
    assign store  = push && !(bypass && data_ready_i);
    assign unload = pop && !bypass;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (store) begin
            wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
        end
        if (unload) begin
            rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
        end
        if (store && !unload) begin
            count_d = count_q + 1'b1;
        end else if (unload && !store) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_clk_ni) begin
        if (!rst_clk_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (store) begin
                mem_q[wr_ptr_q] <= data_i;
            end
        end
    end

endmodule

// File: tb/tb_skid_fifo.sv
// Bench for skid_fifo: four configurations share one stimulus port through a selector,
// a scoreboard queue holds accepted beats and a monitor checks every delivered beat.
module tb_skid_fifo;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [7:0] din;
    logic       vin;
    logic       rin;
    int         sel;

    logic [3:0] vi, rdy, vld, fl, em;
    logic [7:0] dout [4];
    logic [1:0] c0;
    logic [2:0] c1;
    logic [1:0] c2;
    logic [1:0] c3;

    logic [7:0] m_data;
    logic       m_valid, m_ready, m_full, m_empty;
    logic [2:0] m_count;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q [$];

    always_comb begin
        for (int k = 0; k < 4; k++) vi[k] = vin && (sel == k);
    end

    skid_fifo #(.DATA_SIZE(8), .DEPTH(2), .FALL_THROUGH(1'b0)) u_r2 (
        .clk_i(clk), .rst_clk_ni(rst_n), .data_i(din), .data_valid_i(vi[0]),
        .data_ready_o(rdy[0]), .data_o(dout[0]), .data_valid_o(vld[0]),
        .data_ready_i(rin), .count_o(c0), .full_o(fl[0]), .empty_o(em[0]));
    skid_fifo #(.DATA_SIZE(8), .DEPTH(4), .FALL_THROUGH(1'b0)) u_r4 (
        .clk_i(clk), .rst_clk_ni(rst_n), .data_i(din), .data_valid_i(vi[1]),
        .data_ready_o(rdy[1]), .data_o(dout[1]), .data_valid_o(vld[1]),
        .data_ready_i(rin), .count_o(c1), .full_o(fl[1]), .empty_o(em[1]));
    skid_fifo #(.DATA_SIZE(8), .DEPTH(2), .FALL_THROUGH(1'b1)) u_f2 (
        .clk_i(clk), .rst_clk_ni(rst_n), .data_i(din), .data_valid_i(vi[2]),
        .data_ready_o(rdy[2]), .data_o(dout[2]), .data_valid_o(vld[2]),
        .data_ready_i(rin), .count_o(c2), .full_o(fl[2]), .empty_o(em[2]));
    skid_fifo #(.DATA_SIZE(8), .DEPTH(3), .FALL_THROUGH(1'b1)) u_f3 (
        .clk_i(clk), .rst_clk_ni(rst_n), .data_i(din), .data_valid_i(vi[3]),
        .data_ready_o(rdy[3]), .data_o(dout[3]), .data_valid_o(vld[3]),
        .data_ready_i(rin), .count_o(c3), .full_o(fl[3]), .empty_o(em[3]));

    always_comb begin
        m_data  = dout[sel];
        m_valid = vld[sel];
        m_ready = rdy[sel];
        m_full  = fl[sel];
        m_empty = em[sel];
        case (sel)
            0:       m_count = {1'b0, c0};
            1:       m_count = c1;
            2:       m_count = {1'b0, c2};
            default: m_count = {1'b0, c3};
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard on every downstream handshake.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (rst_n && m_valid && rin) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got %0h, expected none", m_data);
                end else begin
                    check("beat", {24'h0, m_data}, {24'h0, exp_q.pop_front()});
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the beat has been accepted.
    task automatic send(input logic [7:0] d);
        int n;
        n = 0;
        din = d;
        vin = 1'b1;
        forever begin
            @(negedge clk);
            if (m_ready) begin
                exp_q.push_back(d);
                break;
            end
            n++;
            if (n > 60) begin
                check("send_timeout", 32'd1, 32'd0);
                break;
            end
        end
        @(posedge clk);
        #1;
        vin = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("drain_empty", exp_q.size(), 0);
    endtask

    task automatic stream(input int s);
        time t0;
        sel = s;
        rin = 1'b1;
        t0 = $time;
        for (int i = 0; i < 100; i++) begin
            din = 8'(i);
            vin = 1'b1;
            @(negedge clk);
            check("stream_ready", {31'h0, m_ready}, 1);
            if (m_ready) exp_q.push_back(8'(i));
            if (s == 2) begin
                check("ft_same_cycle_data", {24'h0, m_data}, i);
                check("ft_same_cycle_valid", {31'h0, m_valid}, 1);
            end
            check("stream_count_le1", {31'h0, (m_count <= 3'd1)}, 1);
            @(posedge clk);
            #1;
        end
        vin = 1'b0;
        check("stream_rate", 32'($time - t0), 1000);
        drain();
    endtask

    localparam logic [15:0] STALL_PAT = 16'b1011_0010_1101_0011;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        din = '0;
        vin = 1'b0;
        rin = 1'b0;
        sel = 0;
        #12;
        // Reset state
        check("rst_valid", {31'h0, m_valid}, 0);
        check("rst_ready", {31'h0, m_ready}, 1);
        check("rst_count", {29'h0, m_count}, 0);
        check("rst_empty", {31'h0, m_empty}, 1);
        check("rst_full", {31'h0, m_full}, 0);
        check("rst_data", {24'h0, m_data}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single beat, registered D2
        rin = 1'b1;
        send(8'hA5);
        check("t1_valid_c1", {31'h0, m_valid}, 1);
        check("t1_data_c1", {24'h0, m_data}, 32'hA5);
        check("t1_count_c1", {29'h0, m_count}, 1);
        @(posedge clk);
        #1;
        check("t1_count_c2", {29'h0, m_count}, 0);
        check("t1_empty_c2", {31'h0, m_empty}, 1);
        drain();

        // Backpressure fill, registered D4
        sel = 1;
        rin = 1'b0;
        fork
            begin
                for (int d = 1; d <= 5; d++) send(8'(d));
            end
            begin
                repeat (5) @(posedge clk);
                #2;
                check("bp_full", {31'h0, m_full}, 1);
                check("bp_ready", {31'h0, m_ready}, 0);
                check("bp_count", {29'h0, m_count}, 4);
                check("bp_head", {24'h0, m_data}, 1);
                rin = 1'b1;
            end
        join
        drain();

        // Streaming, both modes
        stream(0);
        stream(2);

        // Fall-through stall capture, D3
        sel = 3;
        rin = 1'b0;
        send(8'h11);
        check("ft_cap_count1", {29'h0, m_count}, 1);
        check("ft_cap_data1", {24'h0, m_data}, 32'h11);
        send(8'h22);
        check("ft_cap_count2", {29'h0, m_count}, 2);
        check("ft_cap_hold", {24'h0, m_data}, 32'h11);
        rin = 1'b1;
        drain();

        // Wrap-around with stall pattern, D3
        rin = 1'b0;
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    send(8'h30 + 8'(i));
                    if (i % 3 == 1) begin
                        @(posedge clk);
                        #1;
                    end
                end
            end
            begin
                for (int c = 0; c < 40; c++) begin
                    rin = STALL_PAT[c % 16];
                    @(posedge clk);
                    #1;
                end
                rin = 1'b1;
            end
        join
        drain();

        // Asynchronous reset mid-operation, registered D2
        sel = 0;
        rin = 1'b0;
        send(8'h01);
        send(8'h02);
        check("ar_count_before", {29'h0, m_count}, 2);
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        check("ar_valid", {31'h0, m_valid}, 0);
        check("ar_count", {29'h0, m_count}, 0);
        check("ar_ready", {31'h0, m_ready}, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        rin = 1'b1;
        send(8'h7E);
        drain();
        repeat (5) @(posedge clk);
        #1;
        check("ar_final_empty", {31'h0, m_empty}, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/skid_fifo.md
Name: skid_fifo

Overview:
- Parametrised elastic buffer on a valid/ready stream. Successor to the two-state skid buffer.
- Generalised to DEPTH entries, with a selectable zero-latency fall-through or fully registered output mode.
- data_ready_o is driven from registers only, so there is no combinational ready path from data_ready_i to data_ready_o.
- Inserted between pipeline stages to break timing and absorb downstream stalls.

Parameters:
DATA_SIZE, 8, payload width in bits (>=1)
DEPTH, 2, storage entries (>=1); any integer, power of two not required
FALL_THROUGH, 0, 1 = bypass to output when empty (0-cycle latency); 0 = output always from storage (1-cycle latency)

Ports:
Clock and reset are decided: one clock, clk_i; reset rst_clk_ni is asynchronous and active-low.
clk_i  in  1  clock, all state on rising edge
rst_clk_ni  in  1  asynchronous active-low reset
data_i  in  DATA_SIZE  upstream payload
data_valid_i  in  1  upstream valid
data_ready_o  out  1  upstream ready
data_o  out  DATA_SIZE  downstream payload
data_valid_o  out  1  downstream valid
data_ready_i  in  1  downstream ready
count_o  out  $clog2(DEPTH+1)  entries currently stored
full_o  out  1  count_o == DEPTH
empty_o  out  1  count_o == 0

Behaviour:
- Reset (asserted at any time, clock-independent): immediately set count=0, wr_ptr=0, rd_ptr=0 and clear all storage to 0. Resulting outputs: data_valid_o=0 (registered mode; in FT mode it follows data_valid_i), data_ready_o=1, count_o=0, empty_o=1, full_o=0, data_o=0 (registered mode). Stored data in flight is discarded. Release takes effect on the next rising edge.
- push = data_valid_i & data_ready_o; pop = data_valid_o & data_ready_i.
- data_ready_o = !full_o, a function of count only.
- Pointers: wr_ptr advances on a stored push, rd_ptr on a pop from storage. Each wraps DEPTH-1 -> 0 with explicit compare; no power-of-two masking.
- count: +1 on stored push without pop, -1 on pop from storage without push, unchanged on both. Never exceeds DEPTH or goes below 0.
- FALL_THROUGH=0:
  - data_valid_o = !empty_o; data_o = mem[rd_ptr].
  - First beat appears 1 cycle after push.
  - Full throughput (1 beat/cycle) requires DEPTH>=2. DEPTH=1 gives max 1 beat per 2 cycles; this is legal.
- FALL_THROUGH=1:
  - When count==0: data_o = data_i, data_valid_o = data_valid_i.
  - push & pop in the same cycle with count==0: beat passes straight through and is not stored; count stays 0.
  - push & !data_ready_i with count==0: beat is stored; count becomes 1.
  - When count>0: behaves as registered mode, with ordering strictly FIFO.
- Simultaneous push and pop with 0<count<DEPTH: count unchanged, both pointers advance.
- Full: data_ready_o=0, so no push is possible. A pop on a full cycle raises data_ready_o the next cycle (registered ready, by design one-cycle bubble on the input side).
- Output stability: while data_valid_o=1 and data_ready_i=0 with count>0, data_o and data_valid_o hold until pop.
- Upstream rule: data_valid_i, once high, must stay high with data_i stable until push. The block does not check this.
- Ordering: output order equals input order; no loss or duplication.
- No sticky errors or status. count_o, full_o and empty_o are registered-state decodes.

Test Plan:
- Reset then idle, FALL_THROUGH=0, DEPTH=2: push 0xA5 at cycle 0 with data_ready_i=1 -> data_valid_o=1, data_o=0xA5 at cycle 1; count_o returns to 0 at cycle 2.
- Backpressure fill, DEPTH=4: hold data_ready_i=0 and push 0x01..0x05 -> 0x01..0x04 accepted, full_o=1, data_ready_o=0, 0x05 held. Release ready -> output 0x01,0x02,0x03,0x04,0x05 in order, one per cycle once the pipe is primed.
- Streaming, DEPTH=2, both modes: continuous valid and ready for 100 beats of an incrementing counter -> 1 beat/cycle, count_o <= 1, sequence intact. FT mode: data_o == data_i in the same cycle.
- FT stall capture, FALL_THROUGH=1, DEPTH=3: push 0x11 with data_ready_i=0 -> count_o=1 next cycle and data_o=0x11 held stable. Push 0x22 -> count_o=2. Ready=1 -> 0x11 then 0x22.
- Wrap-around, DEPTH=3 (non-power-of-two): 10 pushes interleaved with random stalls -> pointers wrap 2->0 and a scoreboard matches all 10 beats.
- Async reset mid-operation: with count_o=2, assert rst_clk_ni between clock edges -> data_valid_o=0 and count_o=0 before the next edge. After release, push 0x7E -> only 0x7E is delivered.
